chorus_tap_ctrl: RTL and testbench

Controller that sequences a ram_1r1w_sync instance as a modulated delay line for the chorus effect. Per accepted sample it:
- writes the sample at the write pointer;
- computes an LFO-modulated read address behind the write pointer and issues the RAM read;
- returns the dry sample and the delayed (wet) sample together on a ready/valid output.
It sits between the input sample stream and the chorus mixer. The RAM is instantiated outside this block and driven through the RAM ports.

---
 rtl/chorus_tap_ctrl.sv | 143 ++++++++++++++
 tb/tb_chorus_tap_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chorus_tap_ctrl.sv
// chorus_tap_ctrl
// Sequences an external synchronous 1R1W RAM as a modulated delay line for a
// chorus effect. Each accepted sample is written at the write pointer while a
// read is issued at an LFO-modulated distance behind it. One cycle later the
// RAM data is captured as the wet sample. The dry and wet samples are then
// presented together on the output.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. valid_o, once raised, holds with dry_o/wet_o stable until
// ready_i is seen high. ready_o never depends on valid_i.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   data_i/valid_i/ready_o  input sample stream
//   rate_i, depth_i        LFO phase increment and modulation depth (taken at accept)
//   valid_o/dry_o/wet_o/ready_i  output stream (dry and delayed samples)
//   wr_valid_o/wr_addr_o/wr_data_o  RAM write port
//   rd_valid_o/rd_addr_o/rd_data_i  RAM read port (data one cycle after enable)
//   dbg_state             current FSM state (0 IDLE, 1 WAIT, 2 OUT)
module chorus_tap_ctrl #(
    parameter int width_p      = 16,
    parameter int depth_p      = 1024,
    parameter int base_delay_p = 512,
    parameter int lfo_width_p  = 16,
    localparam int addr_w      = $clog2(depth_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [lfo_width_p-1:0] rate_i,
    input  logic [addr_w-1:0]      depth_i,
    output logic                   valid_o,
    output logic [width_p-1:0]     dry_o,
    output logic [width_p-1:0]     wet_o,
    input  logic                   ready_i,
    output logic                   wr_valid_o,
    output logic [addr_w-1:0]      wr_addr_o,
    output logic [width_p-1:0]     wr_data_o,
    output logic                   rd_valid_o,
    output logic [addr_w-1:0]      rd_addr_o,
    input  logic [width_p-1:0]     rd_data_i,
    output logic [1:0]             dbg_state
);

    localparam int tri_w = lfo_width_p - 1;
    localparam logic [addr_w-1:0] dep_max  = addr_w'(base_delay_p - 1);
    localparam logic [addr_w-1:0] base_d   = addr_w'(base_delay_p);
    localparam logic [addr_w:0]   fill_max = (addr_w + 1)'(depth_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [addr_w-1:0]       wr_ptr;
    logic [lfo_width_p-1:0]  phase;
    logic [addr_w:0]         fill;
    logic                    zero;
    logic                    accept;

    logic [tri_w-1:0]        tri_val;
    logic [addr_w-1:0]       dep;
    logic [tri_w+addr_w-1:0] prod;
    logic [addr_w-1:0]       offset;
    logic [addr_w-1:0]       d;

    // Triangle LFO from the pre-update phase. Since offset <= dep <= base-1,
    // d stays in 1..base, so the read never lands on the write address.
    always_comb begin
        tri_val = phase[lfo_width_p-1] ? ~phase[tri_w-1:0] : phase[tri_w-1:0];
        dep     = (depth_i > dep_max) ? dep_max : depth_i;
        prod    = {{addr_w{1'b0}}, tri_val} * {{tri_w{1'b0}}, dep};
        offset  = prod[tri_w +: addr_w];
        d       = base_d - offset;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n = state;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state)
            IDLE: ready_o = 1'b1;
            WAIT: state_n = OUT;
            OUT: begin
                valid_o = 1'b1;
                ready_o = ready_i;
            end
            default: state_n = IDLE;
        endcase
        // A new sample may enter in the same cycle the previous output leaves.
        accept = valid_i & ready_o & ~reset_i;
        if (state == IDLE && accept) begin
            state_n = WAIT;
        end else if (state == OUT && ready_i) begin
            state_n = accept ? WAIT : IDLE;
        end
    end

    // RAM port drive: both accesses happen only in the accept cycle.
    always_comb begin
        wr_valid_o = accept;
        wr_addr_o  = wr_ptr;
        wr_data_o  = data_i;
        rd_valid_o = accept;
        rd_addr_o  = wr_ptr - d;   // wraps naturally, depth is a power of two
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= IDLE;
            wr_ptr <= '0;
            phase  <= '0;
            fill   <= '0;
            zero   <= 1'b0;
            dry_o  <= '0;
            wet_o  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                dry_o  <= data_i;
                // Too few samples written yet: the tap would hit unwritten RAM.
                zero   <= (fill < {1'b0, d});
                phase  <= phase + rate_i;
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != fill_max) begin
                    fill <= fill + 1'b1;
                end
            end
            if (state == WAIT) begin
                wet_o <= zero ? '0 : rd_data_i;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_chorus_tap_ctrl.sv
module tb_chorus_tap_ctrl;

  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int BASE  = 8;
  localparam int LFO_W = 4;
  localparam int AW    = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic [W-1:0]     data_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [LFO_W-1:0] rate_i = '0;
  logic [AW-1:0]    depth_i = '0;
  logic             valid_o;
  logic [W-1:0]     dry_o;
  logic [W-1:0]     wet_o;
  logic             ready_i = 1'b1;
  logic             wr_valid_o;
  logic [AW-1:0]    wr_addr_o;
  logic [W-1:0]     wr_data_o;
  logic             rd_valid_o;
  logic [AW-1:0]    rd_addr_o;
  logic [W-1:0]     rd_data_i = '0;
  logic [1:0]       dbg_state;

  chorus_tap_ctrl #(
    .width_p(W), .depth_p(DEPTH), .base_delay_p(BASE), .lfo_width_p(LFO_W)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .rate_i(rate_i), .depth_i(depth_i),
    .valid_o(valid_o), .dry_o(dry_o), .wet_o(wet_o), .ready_i(ready_i),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_valid_o(rd_valid_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .dbg_state(dbg_state)
  );

  // ---------------- RAM model (garbage-filled, sync read) ----------------
  logic [W-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);

  always @(posedge clk) begin
    if (wr_valid_o) mem[wr_addr_o] <= wr_data_o;
    rd_data_i <= rd_valid_o ? mem[rd_addr_o] : W'($urandom);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0]    exp_q[$];
  int                lat_q[$];
  logic [2*AW+W-1:0] addr_q[$];

  // reference model state
  logic [W-1:0] hist[$];
  int phase_m = 0;
  int last_acc = 0;
  bit have_last = 0;
  bit chk_gap = 0;
  bit bp_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Delay from the triangle-LFO rule in plain integer arithmetic.
  function automatic int model_d(input int ph, input int dep_in);
    int half, tv, dp;
    half = 1 << (LFO_W - 1);
    tv = (ph < half) ? ph : (2 * half - 1 - ph);
    dp = (dep_in < BASE - 1) ? dep_in : BASE - 1;
    return BASE - (tv * dp) / half;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [W-1:0] data, input logic [LFO_W-1:0] rate,
                      input logic [AW-1:0] dep);
    bit seen;
    int d, ptr, ra;
    logic [W-1:0] wet;
    valid_i = 1'b1;
    data_i  = data;
    rate_i  = rate;
    depth_i = dep;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ready_o) seen = 1;
    end
    if (!seen) begin
      fail("accept_timeout");
    end else begin
      d   = model_d(phase_m, int'(dep));
      wet = (hist.size() < d) ? '0 : hist[hist.size() - d];
      ptr = hist.size() % DEPTH;
      ra  = (ptr - d + DEPTH) % DEPTH;
      exp_q.push_back({data, wet});
      lat_q.push_back(cyc);
      addr_q.push_back({AW'(ptr), AW'(ra), data});
      hist.push_back(data);
      phase_m = (phase_m + int'(rate)) % (1 << LFO_W);
      if (chk_gap && have_last) check("accept_gap", 32'(cyc - last_acc), 32'd2);
      last_acc  = cyc;
      have_last = 1;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic flush_model();
    exp_q.delete();
    lat_q.delete();
    addr_q.delete();
    hist.delete();
    phase_m = 0;
    have_last = 0;
  endtask

  // Called at posedge+#1; holds reset across one edge and checks the result.
  task automatic apply_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    flush_model();
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_dry_wet", {dry_o, wet_o}, 32'd0);
    check("rst_ram_en", 32'({wr_valid_o, rd_valid_o}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // random output backpressure
  always @(posedge clk) begin
    if (bp_mode) begin
      #1;
      ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- output monitor ----------------
  bit prev_valid = 0;
  bit prev_hs = 0;
  logic [2*W-1:0] prev_data = '0;

  always @(negedge clk) begin
    logic [2*W-1:0] e;
    int l;
    if (!reset_i && valid_o) begin
      if (!prev_valid || prev_hs) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("out_dry_wet", {dry_o, wet_o}, e);
          check("out_latency", 32'(cyc), 32'(l + 2));
        end
      end else begin
        check("hold_dry_wet", {dry_o, wet_o}, prev_data);
      end
      if (!ready_i) begin
        check("stall_ram_en", 32'({wr_valid_o, rd_valid_o}), 32'd0);
        check("stall_ready", 32'(ready_o), 32'd0);
      end
    end
    prev_valid = valid_o && !reset_i;
    prev_hs    = valid_o && ready_i;
    prev_data  = {dry_o, wet_o};
  end

  // ---------------- RAM port monitor ----------------
  always @(negedge clk) begin
    #2;
    if (!reset_i && wr_valid_o) begin
      if (addr_q.size() == 0) fail("unexpected_ram_write");
      else check("ram_wr_rd_addr_data", 32'({wr_addr_o, rd_addr_o, wr_data_o}), 32'(addr_q.pop_front()));
      check("ram_rd_en", 32'(rd_valid_o), 32'd1);
    end else if (!reset_i && rd_valid_o) begin
      fail("stray_ram_read");
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int rel;
    @(posedge clk);
    #1;
    apply_reset();

    // idle after reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_valid", 32'(valid_o), 32'd0);
    check("idle_ready", 32'(ready_o), 32'd1);
    check("idle_dry_wet", {dry_o, wet_o}, 32'd0);
    check("idle_ram_en", 32'({wr_valid_o, rd_valid_o}), 32'd0);
    @(posedge clk);
    #1;

    // fixed delay stream 1..20, pointer wraps
    ready_i = 1'b1;
    chk_gap = 1;
    for (int n = 1; n <= 20; n++) send(W'(n), '0, '0);
    chk_gap = 0;
    drain();

    // stall with output pending, release accepts a waiting sample
    ready_i = 1'b0;
    send(W'(100), '0, '0);
    for (int i = 0; i < 20 && !valid_o; i++) @(negedge clk);
    if (!valid_o) fail("stall_valid_timeout");
    @(posedge clk);
    #1;
    rel = -1;
    fork
      send(W'(101), '0, '0);
      begin
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        rel = cyc;
      end
    join
    check("release_accept_cycle", 32'(last_acc), 32'(rel));
    drain();

    // LFO delay values, then same with depth beyond the clamp
    apply_reset();
    for (int k = 0; k < 4; k++) send(W'(200 + k), 4'd4, 4'd7);
    for (int k = 0; k < 4; k++) send(W'(300 + k), 4'd4, 4'd15);
    drain();

    // back-to-back random stream, fill saturates
    apply_reset();
    chk_gap = 1;
    for (int k = 0; k < 40; k++)
      send(W'($urandom), LFO_W'($urandom), AW'($urandom));
    chk_gap = 0;
    drain();

    // random stream with backpressure and idle gaps
    bp_mode = 1;
    for (int k = 0; k < 60; k++) begin
      send(W'($urandom), LFO_W'($urandom), AW'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    bp_mode = 0;
    @(posedge clk);
    #1;
    ready_i = 1'b1;

    // reset while in WAIT, then warm-up again
    apply_reset();
    for (int k = 0; k < 12; k++) send(W'($urandom_range(1, 65535)), '0, '0);
    check("pre_reset_state", 32'(dbg_state), 32'd1);
    apply_reset();
    for (int k = 0; k < 8; k++) send(W'($urandom_range(1, 65535)), '0, '0);
    drain();

    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_addr_q_empty", 32'(addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
